// File: rtl/mul_ctrl.sv
// Multiply issue controller: one in-flight stage tracking the external multiplier,
// followed by a 3-entry in-order result FIFO with valid/ready handshakes.
module mul_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [4:0]  in_dest,
  input  logic        flush,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_is_signed,
  input  logic [63:0] mul_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_dest
);

  localparam int unsigned DEPTH = 3;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  dest;
  } entry_t;

  entry_t      mem_q [DEPTH];
  entry_t      mem_d [DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        f_valid_q, f_valid_d;
  logic [1:0]  f_op_q, f_op_d;
  logic [4:0]  f_dest_q, f_dest_d;

  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] sel_result;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    // Credit covers the in-flight op so a push can never hit a full FIFO.
    in_ready      = !reset && !flush &&
                    (({1'b0, count_q} + {2'b00, f_valid_q}) < 3'd3);
    accept        = in_valid && in_ready;
    mul_a         = in_src1;
    mul_b         = in_src2;
    mul_is_signed = (in_op != 2'b10);
    sel_result    = (f_op_q == 2'b01 || f_op_q == 2'b10) ? mul_product[63:32]
                                                         : mul_product[31:0];
    out_valid     = (count_q != 2'd0);
    out_result    = mem_q[rd_ptr_q].result;
    out_dest      = mem_q[rd_ptr_q].dest;
    push          = f_valid_q;
    pop           = out_valid && out_ready;

    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    f_valid_d = f_valid_q;
    f_op_d    = f_op_q;
    f_dest_d  = f_dest_q;

    if (flush) begin
      f_valid_d = 1'b0;
      count_d   = 2'd0;
      wr_ptr_d  = 2'd0;
      rd_ptr_d  = 2'd0;
    end else begin
      f_valid_d = accept;
      if (accept) begin
        f_op_d   = in_op;
        f_dest_d = in_dest;
      end
      if (push) begin
        mem_d[wr_ptr_q] = '{result: sel_result, dest: f_dest_q};
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      f_valid_q <= 1'b0;
      f_op_q    <= '0;
      f_dest_q  <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      f_valid_q <= f_valid_d;
      f_op_q    <= f_op_d;
      f_dest_q  <= f_dest_d;
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a one-cycle registered multiplier model.
module tb_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_dest;
  logic        flush;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_is_signed;
  logic [63:0] mul_product = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_dest;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  mul_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_src1      (in_src1),
    .in_src2      (in_src2),
    .in_dest      (in_dest),
    .flush        (flush),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_is_signed(mul_is_signed),
    .mul_product  (mul_product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_dest     (out_dest)
  );

  always #5 clk = ~clk;

  // External multiplier: product registered one cycle after operands.
  always @(posedge clk) begin
    if (mul_is_signed)
      mul_product <= $signed({{32{mul_a[31]}}, mul_a}) * $signed({{32{mul_b[31]}}, mul_b});
    else
      mul_product <= {32'h0, mul_a} * {32'h0, mul_b};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single op with out_ready=1; checks one-cycle-in-flight latency and result.
  task automatic run_single(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] dest,
                            input logic [31:0] exp);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_src1   = a;
    in_src2   = b;
    in_dest   = dest;
    #1;
    chk({tag, " in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    #1;
    chk({tag, " inflight out_valid"}, out_valid, 0);
    step();
    chk({tag, " out_valid"}, out_valid, 1);
    chk({tag, " result"}, out_result, exp);
    chk({tag, " dest"}, out_dest, dest);
    step();
    chk({tag, " drained"}, out_valid, 0);
  endtask

  logic exp_rdy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
    in_dest = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_result", out_result, 0);
    chk("rst out_dest", out_dest, 0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("post-rst in_ready", in_ready, 1);

    // Combinational multiplier drive
    in_op = 2'b10; in_src1 = 32'h1234_5678; in_src2 = 32'h9abc_def0;
    #1;
    chk("mul_a", mul_a, 32'h1234_5678);
    chk("mul_b", mul_b, 32'h9abc_def0);
    chk("mul_is_signed op10", mul_is_signed, 0);
    in_op = 2'b11;
    #1;
    chk("mul_is_signed op11", mul_is_signed, 1);
    step();

    run_single("mulw 7x6",   2'b00, 32'h7,          32'h6,          5'd3,  32'h0000_002A);
    run_single("mulh -1",    2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4,  32'h0000_0000);
    run_single("mulhu -1",   2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE);
    run_single("mulw -1",    2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0001);
    run_single("op11 -1",    2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7,  32'h0000_0001);
    run_single("mulh 8e",    2'b01, 32'h8000_0000,  32'h8000_0000,  5'd8,  32'h4000_0000);
    run_single("mulhu 8e",   2'b10, 32'h8000_0000,  32'h8000_0000,  5'd9,  32'h4000_0000);
    run_single("mulh 8e x2", 2'b01, 32'h8000_0000,  32'h0000_0002,  5'd10, 32'hFFFF_FFFF);

    // Backpressure: only three ops fit (two in FIFO + one in flight, then three in FIFO)
    out_ready = 1'b0;
    in_op = 2'b00; in_src2 = 32'd10;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_dest  = 5'(i);
      in_src1  = 32'(i);
      #1;
      chk($sformatf("bp in_ready op%0d", i), in_ready, exp_rdy[i-1]);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("bp out_valid %0d", i), out_valid, 1);
      chk($sformatf("bp dest %0d", i), out_dest, 5'(i));
      chk($sformatf("bp result %0d", i), out_result, 32'(i * 10));
      step();
    end
    chk("bp drained", out_valid, 0);

    // Remaining ops 4,5 back to back across the wrapped pointers
    in_valid = 1'b1; in_dest = 5'd4; in_src1 = 32'd4;
    #1;
    chk("bb in_ready 4", in_ready, 1);
    step();
    in_dest = 5'd5; in_src1 = 32'd5;
    #1;
    chk("bb in_ready 5", in_ready, 1);
    step();
    in_valid = 1'b0;
    #1;
    chk("bb valid 4", out_valid, 1);
    chk("bb dest 4", out_dest, 5'd4);
    chk("bb result 4", out_result, 32'd40);
    step();
    chk("bb valid 5", out_valid, 1);
    chk("bb dest 5", out_dest, 5'd5);
    chk("bb result 5", out_result, 32'd50);
    step();
    chk("bb drained", out_valid, 0);

    // Flush with two buffered results and one in flight
    out_ready = 1'b0;
    for (int i = 6; i <= 8; i++) begin
      in_valid = 1'b1; in_dest = 5'(i); in_src1 = 32'(i);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("pre-flush out_valid", out_valid, 1);
    chk("pre-flush in_ready", in_ready, 0);
    flush = 1'b1;
    #1;
    chk("flush in_ready low", in_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("post-flush out_valid", out_valid, 0);
    chk("post-flush in_ready", in_ready, 1);
    step();
    chk("post-flush still empty", out_valid, 0);
    run_single("after flush", 2'b00, 32'd9, 32'd9, 5'd17, 32'd81);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    in_valid = 1'b1; in_dest = 5'd20; in_src1 = 32'd3; in_src2 = 32'd3;
    step(); step();
    in_valid = 1'b0;
    #2;
    chk("pre-areset out_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("areset out_valid", out_valid, 0);
    chk("areset in_ready", in_ready, 0);
    chk("areset out_result", out_result, 0);
    chk("areset out_dest", out_dest, 0);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("areset release in_ready", in_ready, 1);
    step();
    run_single("after areset", 2'b10, 32'hFFFF_FFFF, 32'h2, 5'd31, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mul_ctrl.md
MUL_CTRL -- requirements
Module: mul_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: in_valid  in  1  upstream op valid.
REQ-004 SHALL have: in_ready  out  1  block can accept op.
REQ-005 SHALL have: in_op  in  2  00 MUL_W (low 32), 01 MULH_W (high, signed), 10 MULH_WU (high, unsigned), 11 treated as MUL_W.
REQ-006 SHALL have: in_src1, in_src2  in  32 each  operands.
REQ-007 SHALL have: in_dest  in  5  destination tag, returned with result.
REQ-008 SHALL have: flush  in  1  kill all in-flight and buffered ops.
REQ-009 SHALL have: mul_a, mul_b  out  32 each; mul_is_signed  out  1  drive multiplier.
REQ-010 SHALL have: mul_product  in  64  multiplier result, valid the cycle after operands presented.
REQ-011 SHALL have: out_valid  out  1; out_ready  in  1; out_result  out  32; out_dest  out  5.

Function
REQ-012 SHALL accept an op on a rising edge when in_valid && in_ready && !flush.
REQ-013 SHALL drive mul_a=in_src1, mul_b=in_src2 combinationally; mul_is_signed=1 for op 00/01/11, 0 for op 10.
REQ-014 SHALL track the accepted op in one in-flight stage (f_valid, f_op, f_dest) set on the accept edge.
REQ-015 SHALL, while f_valid, select mul_product[31:0] for MUL_W, else mul_product[63:32], and push {result, f_dest} into the result FIFO on the next edge.
REQ-016 Result FIFO SHALL be 3 entries, in order, read/write pointers wrap 2->0, count 0..3.
REQ-017 SHALL set in_ready = !flush && (count + f_valid) < 3; it SHALL NOT depend on out_ready or in_valid.
REQ-018 SHALL set out_valid = count != 0; out_result/out_dest = head entry; pop on out_valid && out_ready.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; push into a full FIFO SHALL never occur by REQ-017.
REQ-020 Latency: op accepted at edge E0 SHALL be visible at out_valid after edge E1 (one cycle in flight, one in FIFO) when FIFO empty.
REQ-021 Throughput: one op per cycle sustained when out_ready held 1.
REQ-022 flush SHALL on the next edge clear f_valid, count, and both pointers; any same-cycle accept and pop are discarded.
REQ-023 out_result/out_dest SHALL be don't-care when out_valid=0 but SHALL NOT be X after reset.

Reset
REQ-024 On reset assertion, SHALL immediately force f_valid=0, count=0, pointers=0, out_valid=0, out_result=0, out_dest=0.
REQ-025 in_ready SHALL read 1 while reset is high is NOT required; in_ready SHALL be 0 during reset and 1 the first cycle after release.
REQ-026 FIFO data storage SHALL be reset to 0.

Verification
REQ-027 MUL_W 0x00000007 x 0x00000006, dest 3, out_ready=1 -> out_valid one cycle after accept edge, result 0x0000002A, dest 3.
REQ-028 src 0xFFFFFFFF x 0xFFFFFFFF: MULH_W -> 0x00000000; MULH_WU -> 0xFFFFFFFE; MUL_W -> 0x00000001.
REQ-029 MULH_W 0x80000000 x 0x80000000 -> 0x40000000; MULH_WU same -> 0x40000000; MULH_W 0x80000000 x 0x00000002 -> 0xFFFFFFFF.
REQ-030 out_ready=0, 5 back-to-back ops dests 1..5 -> exactly 3 accepted (in_ready low after 3rd), then out_ready=1 -> dests 1,2,3 in order, then 4,5 accepted and returned; pointer wrap exercised.
REQ-031 Two results in FIFO plus one in flight, pulse flush -> next cycle out_valid=0, count=0, in_ready=1; next op returns correct result.
REQ-032 Assert reset asynchronously mid-stream (between edges) -> out_valid and in_ready drop to 0 before next edge; after release first op returns correct result.
